fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main/ALU control decoder.
- Holds the PC and issues word fetches to instruction memory over a ready handshake.
- Latches each fetched word into an instruction register and presents Opcode/funct to the decoder.
- Computes the next PC from the decoder's Jump/Branch outputs and the ALU compare result.
- Non-overlapped: one instruction in flight; no branch delay slot.

---
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word at a time over a
// ready handshake and computes the next PC from the decoder's jump/branch.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        alu_cmp,
    output logic [31:0] instr,
    output logic [5:0]  Opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic [31:0] retire_count
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic [31:0] retire_q;
    logic [31:0] br_off;
    logic [31:0] next_pc_d;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jump takes priority over a taken branch when the decoder raises both.
    always_comb begin
        next_pc_d = pc_plus4;
        if (Jump) begin
            next_pc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (Branch && alu_cmp) begin
            next_pc_d = pc_plus4 + br_off;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= PC_RESET;
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
            retire_q <= 32'h0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_q     <= next_pc_d;
                        valid_q  <= 1'b0;
                        retire_q <= retire_q + 32'd1;
                        state_q  <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = {pc_q[31:2], 2'b00};
    assign instr        = instr_q;
    assign Opcode       = instr_q[31:26];
    assign funct        = instr_q[5:0];
    assign pc           = pc_q;
    assign instr_valid  = valid_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a vector table of instructions driven through the
// fetch/hold handshake, with expected fetch addresses kept in a queue.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, hi_imem_req;
    logic [31:0] imem_addr, hi_imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        Jump, Branch, alu_cmp;
    logic [31:0] instr, hi_instr;
    logic [5:0]  Opcode, funct, hi_Opcode, hi_funct;
    logic [31:0] pc, pc_plus4, hi_pc, hi_pc_plus4;
    logic        instr_valid, hi_instr_valid;
    logic [31:0] retire_count, hi_retire_count;

    int passed = 0;
    int total  = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .Jump(Jump), .Branch(Branch), .alu_cmp(alu_cmp),
        .instr(instr), .Opcode(Opcode), .funct(funct),
        .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .retire_count(retire_count)
    );

    // Second instance in the upper 256 MB region, for the jump-region test.
    fetch_unit #(.PC_RESET(32'hF000_0000)) dut_hi (
        .clk(clk), .reset(reset),
        .imem_req(hi_imem_req), .imem_addr(hi_imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .Jump(Jump), .Branch(Branch), .alu_cmp(alu_cmp),
        .instr(hi_instr), .Opcode(hi_Opcode), .funct(hi_funct),
        .pc(hi_pc), .pc_plus4(hi_pc_plus4),
        .instr_valid(hi_instr_valid), .retire_count(hi_retire_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rst_before;
        logic [31:0] rdata;
        int          dly;
        int          stall_cyc;
        logic        j;
        logic        b;
        logic        c;
        logic [31:0] exp_next;
        logic        chk_hi;
        logic [31:0] exp_hi;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] exp_q[$];
    logic [31:0] exp_retire;

    function automatic vec_t mk(input logic rst, input logic [31:0] rdata,
                                input int dly, input int st, input logic j,
                                input logic b, input logic c,
                                input logic [31:0] nxt, input logic chk_hi,
                                input logic [31:0] nxt_hi);
        vec_t v;
        v.rst_before = rst; v.rdata = rdata; v.dly = dly; v.stall_cyc = st;
        v.j = j; v.b = b; v.c = c; v.exp_next = nxt;
        v.chk_hi = chk_hi; v.exp_hi = nxt_hi;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        imem_ready = 1'b0;
        stall      = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_retire = 32'h0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        check("rst_req",    32'(imem_req),    32'h1);
        check("rst_valid",  32'(instr_valid), 32'h0);
        check("rst_instr",  instr,            32'h0);
        check("rst_retire", retire_count,     32'h0);
        check("rst_pc",     pc,               32'h0);
        check("rst_hi_pc",  hi_pc,            32'hF000_0000);
    endtask

    task automatic run_instr(input vec_t v);
        logic [31:0] cur;
        if (v.rst_before) do_reset();
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'h1, 32'h0);
            cur = 32'h0;
        end else begin
            cur = exp_q.pop_front();
        end
        check("fetch_addr", imem_addr, cur);
        check("fetch_req",  32'(imem_req), 32'h1);
        // Decoder inputs are don't-care outside the consuming edge.
        Jump    = ($urandom % 2) == 1;
        Branch  = ($urandom % 2) == 1;
        alu_cmp = ($urandom % 2) == 1;
        for (int i = 0; i < v.dly; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            @(posedge clk);
            #1;
            check("wait_req",   32'(imem_req),    32'h1);
            check("wait_addr",  imem_addr,        cur);
            check("wait_valid", 32'(instr_valid), 32'h0);
        end
        imem_ready = 1'b1;
        imem_rdata = v.rdata;
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        check("hold_valid",  32'(instr_valid), 32'h1);
        check("hold_instr",  instr,            v.rdata);
        check("hold_opcode", 32'(Opcode),      32'(v.rdata[31:26]));
        check("hold_funct",  32'(funct),       32'(v.rdata[5:0]));
        check("hold_pc",     pc,               cur);
        check("hold_pc4",    pc_plus4,         cur + 32'd4);
        check("hold_req",    32'(imem_req),    32'h0);
        for (int i = 0; i < v.stall_cyc; i++) begin
            stall      = 1'b1;
            imem_ready = 1'b1;
            imem_rdata = ~v.rdata;
            Jump = 1'b1; Branch = 1'b1; alu_cmp = 1'b1;
            @(posedge clk);
            #1;
            check("stall_instr",  instr,            v.rdata);
            check("stall_pc",     pc,               cur);
            check("stall_retire", retire_count,     exp_retire);
            check("stall_valid",  32'(instr_valid), 32'h1);
            check("stall_req",    32'(imem_req),    32'h0);
        end
        stall      = 1'b0;
        imem_ready = 1'b0;
        Jump = v.j; Branch = v.b; alu_cmp = v.c;
        exp_q.push_back(v.exp_next);
        @(posedge clk);
        #1;
        exp_retire = exp_retire + 32'd1;
        check("cons_valid",  32'(instr_valid), 32'h0);
        check("cons_retire", retire_count,     exp_retire);
        check("cons_req",    32'(imem_req),    32'h1);
        if (v.chk_hi) check("cons_hi_addr", hi_imem_addr, v.exp_hi);
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        Jump = 1'b0; Branch = 1'b0; alu_cmp = 1'b0;

        // Zero-wait ADDI stream; alu_cmp alone must not redirect.
        vecs[0]  = mk(1, 32'h20080005, 0, 0, 0, 0, 0, 32'h4,  0, 0);
        vecs[1]  = mk(0, 32'h20080005, 0, 0, 0, 0, 1, 32'h8,  0, 0);
        vecs[2]  = mk(0, 32'h20080005, 0, 0, 0, 0, 0, 32'hC,  0, 0);
        // Slow memory, long stall, then branches around pc=0x10.
        vecs[3]  = mk(1, 32'h20080005, 0, 0, 0, 0, 0, 32'h4,  0, 0);
        vecs[4]  = mk(0, 32'h20080005, 3, 0, 0, 0, 0, 32'h8,  0, 0);
        vecs[5]  = mk(0, 32'h00000020, 0, 5, 0, 0, 0, 32'hC,  0, 0);
        vecs[6]  = mk(0, 32'h20080005, 0, 0, 0, 0, 1, 32'h10, 0, 0);
        vecs[7]  = mk(0, 32'h10000003, 0, 0, 0, 1, 1, 32'h20, 0, 0);
        vecs[8]  = mk(0, 32'h1000FFFB, 0, 0, 0, 1, 1, 32'h10, 0, 0);
        vecs[9]  = mk(0, 32'h10000003, 0, 0, 0, 1, 0, 32'h14, 0, 0);
        vecs[10] = mk(0, 32'h1000FFFE, 0, 0, 0, 1, 1, 32'h10, 0, 0);
        vecs[11] = mk(0, 32'h1000FFFF, 0, 0, 0, 1, 1, 32'h10, 0, 0);
        // Jump and Branch together: Jump wins, region bits from pc+4.
        vecs[12] = mk(1, 32'h08000040, 0, 0, 1, 1, 1, 32'h100, 1, 32'hF0000100);
        // Backward branch below zero, then sequential wrap past the top.
        vecs[13] = mk(1, 32'h1000FFFE, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 0, 0);
        vecs[14] = mk(0, 32'h20080005, 0, 0, 0, 0, 0, 32'h0,  0, 0);
        vecs[15] = mk(0, 32'h20080005, 1, 0, 0, 0, 0, 32'h4,  0, 0);

        for (int i = 0; i < 16; i++) begin
            run_instr(vecs[i]);
            if (i == 2) check("retire_after_3", retire_count, 32'd3);
        end

        // Reset during FETCH with ready high: the returned word is dropped.
        check("pre_rst_addr", imem_addr, exp_q.pop_front());
        imem_ready = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        imem_ready = 1'b0;
        check("midrst_instr",  instr,            32'h0);
        check("midrst_valid",  32'(instr_valid), 32'h0);
        check("midrst_addr",   imem_addr,        32'h0);
        check("midrst_req",    32'(imem_req),    32'h1);
        check("midrst_retire", retire_count,     32'h0);
        @(posedge clk);
        #1;
        check("midrst_wait_valid", 32'(instr_valid), 32'h0);
        check("midrst_wait_addr",  imem_addr,        32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
